// File: rtl/nanocache_miss_responder.sv
// NanoCore data-cache miss / write-back responder: serialises 256-bit lines into 8 SRAM beats.
// Optional feature macro: NANOCACHE_WB_BYPASS_EN (serve fills from the last write-back line).
module nanocache_miss_responder #(
    parameter int MEM_AW = 16,
    parameter int RD_LAT = 1
) (
    input  logic                 i_clk,
    input  logic                 i_rst,
    input  logic                 i_miss_rden,
    input  logic                 i_miss_wren,
    input  logic                 i_wb_wren,
    input  logic [31:0]          i_miss_addr,
    input  logic [7:0][31:0]     i_miss_wdata,
    output logic                 o_miss_resp,
    output logic                 o_wb_gnt,
    output logic                 o_upd_valid,
    output logic [7:0][31:0]     o_upd_rdata,
    output logic                 o_mem_rden,
    output logic                 o_mem_wren,
    output logic [MEM_AW-1:0]    o_mem_addr,
    output logic [31:0]          o_mem_wdata,
    input  logic [31:0]          i_mem_rdata
);

    typedef enum logic [2:0] {IDLE, RD_ISSUE, RD_WAIT, WR, WB} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              beat_q, beat_d;
    logic [31:0]             line_q, line_d;
    logic [7:0][31:0]        buf_q, buf_d;
    logic [7:0][31:0]        fill_q, fill_d;
    logic [RD_LAT-1:0]       pvld_q, pvld_d;
    logic [RD_LAT-1:0][2:0]  ptag_q, ptag_d;
    logic                    rden_q, rden_d;
    logic                    wren_q, wren_d;
    logic [MEM_AW-1:0]       addr_q, addr_d;
    logic [31:0]             wdata_q, wdata_d;
    logic                    resp_q, resp_d;
    logic                    upd_q, upd_d;
    logic                    last_wr_q, last_wr_d;

    logic eff_wren, eff_rden;
    logic acc_wr, acc_rd, acc_wb;
    logic last_vld, last_ret, rd_done;
    logic byp_hit;
    logic [7:0][31:0] byp_line;

    // A request whose completion pulses this cycle is still held; ignore it
    assign eff_wren = i_miss_wren & ~(resp_q & last_wr_q);
    assign eff_rden = i_miss_rden & ~(resp_q & ~last_wr_q);

    assign acc_wr   = (state_q == IDLE) & eff_wren;
    assign acc_rd   = (state_q == IDLE) & ~eff_wren & eff_rden;
    assign acc_wb   = (state_q == IDLE) & ~eff_wren & ~eff_rden & i_wb_wren & ~i_rst;
    assign o_wb_gnt = acc_wb;

    assign last_vld = pvld_q[RD_LAT-1];
    assign last_ret = last_vld & (ptag_q[RD_LAT-1] == 3'd7);
    assign rd_done  = ((state_q == RD_WAIT) & last_ret) | byp_hit;

`ifdef NANOCACHE_WB_BYPASS_EN
    logic             byp_vld_q;
    logic [31:0]      byp_addr_q;
    logic [7:0][31:0] byp_data_q;

    assign byp_hit  = acc_rd & byp_vld_q & (byp_addr_q == i_miss_addr);
    assign byp_line = byp_data_q;

    // Track the most recent write-back line; writes elsewhere invalidate it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            byp_vld_q  <= 1'b0;
            byp_addr_q <= '0;
            byp_data_q <= '0;
        end else if (acc_wb) begin
            byp_vld_q  <= 1'b1;
            byp_addr_q <= i_miss_addr;
            byp_data_q <= i_miss_wdata;
        end else if (acc_wr) begin
            if (i_miss_addr == byp_addr_q) begin
                byp_data_q <= i_miss_wdata;
            end else begin
                byp_vld_q <= 1'b0;
            end
        end
    end
`else
    assign byp_hit  = 1'b0;
    assign byp_line = '0;
`endif

    // FSM state register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) state_q <= IDLE;
        else       state_q <= state_d;
    end

    // FSM next-state logic
    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: begin
                if (acc_wr)                  state_d = WR;
                else if (acc_rd && !byp_hit) state_d = RD_ISSUE;
                else if (acc_wb)             state_d = WB;
            end
            RD_ISSUE: if (beat_q == 3'd7) state_d = RD_WAIT;
            RD_WAIT:  if (last_ret)       state_d = IDLE;
            WR:       if (beat_q == 3'd7) state_d = IDLE;
            WB:       if (beat_q == 3'd7) state_d = IDLE;
            default:                      state_d = IDLE;
        endcase
    end

    // Output and datapath next values (all outputs except o_wb_gnt are registered)
    always_comb begin
        beat_d    = beat_q;
        line_d    = line_q;
        buf_d     = buf_q;
        fill_d    = fill_q;
        addr_d    = addr_q;
        wdata_d   = wdata_q;
        last_wr_d = last_wr_q;
        pvld_d    = '0;
        ptag_d    = '0;
        if (state_q == RD_ISSUE || state_q == WR || state_q == WB) begin
            beat_d = beat_q + 3'd1;
        end
        if (acc_wr || acc_rd || acc_wb) line_d = i_miss_addr;
        if (acc_wr || acc_wb)           buf_d  = i_miss_wdata;
        rden_d = (state_d == RD_ISSUE);
        wren_d = (state_d == WR) || (state_d == WB);
        if (rden_d || wren_d) addr_d  = MEM_AW'({line_d, beat_d});
        if (wren_d)           wdata_d = buf_d[beat_d];
        pvld_d[0] = rden_q;
        ptag_d[0] = beat_q;
        for (int i = 1; i < RD_LAT; i++) begin
            pvld_d[i] = pvld_q[i-1];
            ptag_d[i] = ptag_q[i-1];
        end
        if (last_vld) fill_d[ptag_q[RD_LAT-1]] = i_mem_rdata;
        if (byp_hit)  fill_d = byp_line;
        upd_d  = rd_done;
        resp_d = rd_done || (state_q == WR && beat_q == 3'd7);
        if (resp_d) last_wr_d = (state_q == WR);
    end

    // Datapath and output registers
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            beat_q    <= '0;
            line_q    <= '0;
            buf_q     <= '0;
            fill_q    <= '0;
            pvld_q    <= '0;
            ptag_q    <= '0;
            rden_q    <= 1'b0;
            wren_q    <= 1'b0;
            addr_q    <= '0;
            wdata_q   <= '0;
            resp_q    <= 1'b0;
            upd_q     <= 1'b0;
            last_wr_q <= 1'b0;
        end else begin
            beat_q    <= beat_d;
            line_q    <= line_d;
            buf_q     <= buf_d;
            fill_q    <= fill_d;
            pvld_q    <= pvld_d;
            ptag_q    <= ptag_d;
            rden_q    <= rden_d;
            wren_q    <= wren_d;
            addr_q    <= addr_d;
            wdata_q   <= wdata_d;
            resp_q    <= resp_d;
            upd_q     <= upd_d;
            last_wr_q <= last_wr_d;
        end
    end

    assign o_miss_resp = resp_q;
    assign o_upd_valid = upd_q;
    assign o_upd_rdata = fill_q;
    assign o_mem_rden  = rden_q;
    assign o_mem_wren  = wren_q;
    assign o_mem_addr  = addr_q;
    assign o_mem_wdata = wdata_q;

endmodule
